// File: rtl/textline_render_pkg.sv
// Shared graphics definitions: glyph geometry, glyph lookup latency,
// renderer state encoding and the procedural font used by the glyph store.
package textline_render_pkg;

    localparam int GFX_GLYPH_W   = 8;
    localparam int GFX_GLYPH_H   = 16;
    localparam int GFX_GLYPH_LAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Stand-in font: low code point byte, perturbed by the line index and the
    // upper code point bits so every line of every glyph differs.
    function automatic logic [GFX_GLYPH_W-1:0] font_glyph(input logic [20:0] ucp,
                                                          input logic [3:0]  line);
        font_glyph = ucp[7:0] ^ {ucp[11:8] ^ line, 3'b000, ^ucp[20:12]};
    endfunction

endpackage

// File: rtl/textline_render_fifo_sync.sv
// Synchronous FIFO holding glyph pixel lines between lookup and serializer.
// Reads show the head entry combinationally; rd_en must only be raised when not empty.
module fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        nxt = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= nxt(wr_ptr);
            if (rd_en) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/textline_render.sv
// Renders one line of glyph pixels for a run of characters from text memory.
// Stream handshake: a pixel moves when pix_valid && pix_ready; pix/pix_last hold while stalled.
module textline_render
    import textline_render_pkg::*;
#(
    parameter int WIDTH     = GFX_GLYPH_W,
    parameter int HEIGHT    = GFX_GLYPH_H,
    parameter int UCPW      = 21,
    parameter int ADDRW     = 12,
    parameter int CNTW      = 8,
    parameter int GLYPH_LAT = GFX_GLYPH_LAT,
    parameter int BUF_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [$clog2(HEIGHT)-1:0] line_id,
    input  logic [ADDRW-1:0]          text_base,
    input  logic [CNTW-1:0]           char_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      text_re,
    output logic [ADDRW-1:0]          text_addr,
    input  logic [UCPW-1:0]           text_data,
    output logic [UCPW-1:0]           glyph_ucp,
    output logic [$clog2(HEIGHT)-1:0] glyph_line,
    input  logic [WIDTH-1:0]          glyph_pix,
    output logic                      pix,
    output logic                      pix_valid,
    output logic                      pix_last,
    input  logic                      pix_ready,
    output state_t                    dbg_state
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);

    state_t           state;
    logic [ADDRW-1:0] rd_addr;
    logic [CNTW-1:0]  cnt_r, rd_cnt, out_cnt;
    logic [OW-1:0]    occ;
    logic [GLYPH_LAT:0] tags;
    logic [WIDTH-1:0] sr, fifo_rd;
    logic [BW-1:0]    bit_idx;
    logic             last_char, fifo_empty, xfer, at_last_bit, pop;

    // occ counts lookups in flight plus lines buffered, so a read is only
    // issued when its returning line is guaranteed a FIFO slot.
    assign text_re     = (state == ST_FETCH) && (occ < OW'(BUF_DEPTH));
    assign text_addr   = rd_addr;
    assign glyph_ucp   = text_data;
    assign xfer        = pix_valid & pix_ready;
    assign at_last_bit = (bit_idx == BW'(WIDTH - 1));
    assign pop         = (!pix_valid || (xfer && at_last_bit)) && !fifo_empty;
    assign pix         = sr[0];
    assign pix_last    = pix_valid && last_char && at_last_bit;
    assign dbg_state   = state;

    fifo_sync #(.W(WIDTH), .DEPTH(BUF_DEPTH)) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tags[GLYPH_LAT]),
        .wr_data (glyph_pix),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_addr    <= '0;
            cnt_r      <= '0;
            rd_cnt     <= '0;
            glyph_line <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    rd_addr    <= text_base;
                    cnt_r      <= char_cnt;
                    rd_cnt     <= '0;
                    glyph_line <= line_id;
                    if (char_cnt == '0) begin
                        done <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                        busy  <= 1'b1;
                    end
                end
                ST_FETCH: if (text_re) begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_cnt  <= rd_cnt + 1'b1;
                    if (rd_cnt == cnt_r - 1'b1) state <= ST_DRAIN;
                end
                ST_DRAIN: if (xfer && pix_last) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lookup tags and the pixel serializer; a new line is loaded on the same
    // edge the previous line's final pixel leaves, so the stream has no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tags      <= '0;
            occ       <= '0;
            out_cnt   <= '0;
            sr        <= '0;
            bit_idx   <= '0;
            pix_valid <= 1'b0;
            last_char <= 1'b0;
        end else begin
            tags <= {tags[GLYPH_LAT-1:0], text_re};
            occ  <= occ + OW'(text_re) - OW'(pop);
            if (state == ST_IDLE && start) out_cnt <= '0;
            if (pop) begin
                sr        <= fifo_rd;
                bit_idx   <= '0;
                pix_valid <= 1'b1;
                last_char <= (out_cnt == cnt_r - 1'b1);
                out_cnt   <= out_cnt + 1'b1;
            end else if (xfer && at_last_bit) begin
                sr        <= '0;
                pix_valid <= 1'b0;
                last_char <= 1'b0;
            end else if (xfer) begin
                sr      <= sr >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_textline_render.sv
// Bench for textline_render: text memory and glyph store models around the DUT,
// and a reference that expands each character into its expected pixel run.
module tb_textline_render;
    import textline_render_pkg::*;

    localparam int W   = 8;
    localparam int LAT = 4;
    localparam int D   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  line_id = '0;
    logic [11:0] text_base = '0;
    logic [7:0]  char_cnt = '0;
    logic        busy, done, text_re, pix, pix_valid, pix_last;
    logic        pix_ready = 1'b0;
    logic [11:0] text_addr;
    logic [20:0] text_data = '0;
    logic [20:0] glyph_ucp;
    logic [3:0]  glyph_line;
    logic [7:0]  glyph_pix;
    state_t      dbg_state;

    always #5 clk = ~clk;

    textline_render #(
        .WIDTH(W), .HEIGHT(16), .UCPW(21), .ADDRW(12), .CNTW(8),
        .GLYPH_LAT(LAT), .BUF_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line_id(line_id),
        .text_base(text_base), .char_cnt(char_cnt), .busy(busy), .done(done),
        .text_re(text_re), .text_addr(text_addr), .text_data(text_data),
        .glyph_ucp(glyph_ucp), .glyph_line(glyph_line), .glyph_pix(glyph_pix),
        .pix(pix), .pix_valid(pix_valid), .pix_last(pix_last),
        .pix_ready(pix_ready), .dbg_state(dbg_state)
    );

    // Environment: text memory with 1-cycle read, glyph store with LAT-cycle lookup.
    logic [20:0] tmem [4096];
    logic [7:0]  gpipe [LAT];

    always @(posedge clk) begin
        if (text_re) text_data <= tmem[text_addr];
        gpipe[0] <= font_glyph(glyph_ucp, glyph_line);
        for (int i = 1; i < LAT; i++) gpipe[i] <= gpipe[i-1];
    end
    assign glyph_pix = gpipe[LAT-1];

    int errors = 0;
    int checks = 0;

    logic [1:0]  exp_q[$];
    logic [1:0]  obs_q[$];
    logic [11:0] exp_addr[$];
    logic [11:0] addr_q[$];
    int done_cnt, done_k, first_pv, last_xfer, max_out, stalls, hold_viol;
    bit timed_out;

    task automatic fill_text(input logic [11:0] base, input int n);
        logic [11:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 12'(i);
            tmem[a] = 21'($urandom_range(0, 32'h1FFFFF));
        end
    endtask

    // Reference: each character contributes W pixels, bit 0 first; only the
    // very last pixel of the line carries the last flag.
    task automatic build_exp(input logic [11:0] base, input logic [7:0] n, input logic [3:0] ln);
        logic [7:0]  g;
        logic [11:0] a;
        exp_q.delete();
        exp_addr.delete();
        for (int i = 0; i < int'(n); i++) begin
            a = base + 12'(i);
            exp_addr.push_back(a);
            g = font_glyph(tmem[a], ln);
            for (int b = 0; b < W; b++)
                exp_q.push_back({g[b], (i == int'(n) - 1) && (b == W - 1)});
        end
    endtask

    function automatic int stream_diff();
        int d = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (d < 0 && (i >= obs_q.size() || obs_q[i] !== exp_q[i])) d = i;
        if (d < 0 && obs_q.size() != exp_q.size()) d = exp_q.size();
        return d;
    endfunction

    function automatic int addr_diff();
        int d = -1;
        for (int i = 0; i < exp_addr.size(); i++)
            if (d < 0 && (i >= addr_q.size() || addr_q[i] !== exp_addr[i])) d = i;
        if (d < 0 && addr_q.size() != exp_addr.size()) d = exp_addr.size();
        return d;
    endfunction

    // Drives one start and records the DUT's behaviour cycle by cycle (sampled
    // at negedge). Iteration k=1 is the first cycle after start is sampled.
    task automatic run_line(input logic [11:0] base, input logic [7:0] n, input logic [3:0] ln,
                            input int rmode, input int dup_at, input int stop_pix, input int extra);
        bit   done_seen = 0;
        int   post = 0;
        logic hold_prev = 0;
        logic pix_prev = 0;
        int   outstanding;
        obs_q.delete();
        addr_q.delete();
        done_cnt = 0; done_k = -1; first_pv = -1; last_xfer = -1;
        max_out = 0; stalls = 0; hold_viol = 0; timed_out = 0;
        build_exp(base, n, ln);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            start = (k == 0) || (k == dup_at);
            if (k == 0) begin
                text_base = base; char_cnt = n; line_id = ln;
            end else if (k == dup_at) begin
                text_base = base + 12'd100; char_cnt = 8'd3; line_id = ~ln;
            end
            pix_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (hold_prev && (!pix_valid || pix !== pix_prev)) hold_viol++;
            hold_prev = pix_valid && !pix_ready;
            pix_prev  = pix;
            if (pix_valid && first_pv < 0) first_pv = k;
            if (pix_valid && pix_ready) begin
                obs_q.push_back({pix, pix_last});
                last_xfer = k;
            end
            if (text_re) addr_q.push_back(text_addr);
            if (dbg_state == ST_FETCH && !text_re) stalls++;
            outstanding = addr_q.size() - obs_q.size() / W;
            if (outstanding > max_out) max_out = outstanding;
            if (done_seen) post++;
            if (done) begin
                done_cnt++; done_k = k; done_seen = 1;
            end
            if (done_seen && post >= extra) return;
            if (stop_pix > 0 && obs_q.size() >= stop_pix) return;
        end
        timed_out = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, text_re, pix_valid, pix_last, pix, glyph_line} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {busy, done, text_re, pix_valid, pix_last, pix, glyph_line});
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_zero_count();
        run_line(12'h100, 8'd0, 4'd3, 0, -1, 0, 6);
        checks++;
        if (timed_out || done_k != 1) begin
            errors++;
            $display("FAIL zero_done_time: got k=%0d expected k=1", done_k);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL zero_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (addr_q.size() != 0 || first_pv != -1) begin
            errors++;
            $display("FAIL zero_activity: reads=%0d first_pix_valid=%0d expected 0 and -1", addr_q.size(), first_pv);
        end
    endtask

    task automatic test_known_glyphs();
        int d;
        tmem[12'h010] = 21'h01;
        tmem[12'h011] = 21'h80;
        tmem[12'h012] = 21'hFF;
        run_line(12'h010, 8'd3, 4'd0, 0, -1, 0, 3);
        d = stream_diff();
        checks++;
        if (timed_out || d != -1) begin
            errors++;
            $display("FAIL known_stream: first diff at %0d (got %0d pixels, expected %0d)", d, obs_q.size(), exp_q.size());
        end
        checks++;
        if (first_pv - 1 != LAT + 3) begin
            errors++;
            $display("FAIL known_latency: got %0d expected %0d", first_pv - 1, LAT + 3);
        end
        checks++;
        if (last_xfer - first_pv != 23) begin
            errors++;
            $display("FAIL known_no_gaps: span %0d expected 23", last_xfer - first_pv);
        end
        checks++;
        if (done_k != last_xfer + 1 || done_cnt != 1) begin
            errors++;
            $display("FAIL known_done: done_k=%0d count=%0d expected k=%0d count=1", done_k, done_cnt, last_xfer + 1);
        end
    endtask

    task automatic test_random_stall();
        logic [11:0] base;
        logic [3:0]  ln;
        int d;
        base = 12'($urandom_range(0, 4000));
        ln   = 4'($urandom_range(0, 15));
        fill_text(base, 20);
        run_line(base, 8'd20, ln, 1, -1, 0, 3);
        d = stream_diff();
        checks++;
        if (timed_out || d != -1 || obs_q.size() != 160) begin
            errors++;
            $display("FAIL stall_stream: first diff at %0d (got %0d pixels, expected 160)", d, obs_q.size());
        end
        d = addr_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stall_addr: first diff at %0d (got %0d reads, expected 20)", d, addr_q.size());
        end
        checks++;
        if (max_out > D + 1) begin
            errors++;
            $display("FAIL stall_occupancy: got %0d expected <= %0d", max_out, D + 1);
        end
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL stall_backpressure: got %0d stalled fetch cycles expected > 0", stalls);
        end
        checks++;
        if (hold_viol != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL stall_hold_done: hold violations %0d done count %0d expected 0 and 1", hold_viol, done_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        int d;
        fill_text(12'hFFE, 4);
        run_line(12'hFFE, 8'd4, 4'd9, 0, -1, 0, 2);
        d = addr_diff();
        checks++;
        if (timed_out || d != -1) begin
            errors++;
            $display("FAIL wrap_addr: first diff at %0d (got %0d reads expected 4)", d, addr_q.size());
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL wrap_stream: first diff at %0d", d);
        end
    endtask

    task automatic test_reset_midline();
        logic [11:0] base;
        int d;
        base = 12'($urandom_range(0, 4000));
        fill_text(base, 10);
        run_line(base, 8'd10, 4'd5, 0, -1, 5, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, text_re, pix_valid, pix_last, pix, glyph_line} !== 10'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL midreset_outputs: got %b state %0d expected 0", {busy, done, text_re, pix_valid, pix_last, pix, glyph_line}, dbg_state);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d expected 0", done_cnt);
        end
        rst_n = 1'b1;
        base = 12'($urandom_range(0, 4000));
        fill_text(base, 7);
        run_line(base, 8'd7, 4'd12, 1, -1, 0, 3);
        d = stream_diff();
        checks++;
        if (timed_out || d != -1 || done_cnt != 1) begin
            errors++;
            $display("FAIL midreset_after: first diff %0d done count %0d expected -1 and 1", d, done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        logic [11:0] base;
        int d;
        base = 12'($urandom_range(0, 3900));
        fill_text(base, 6);
        fill_text(base + 12'd100, 3);
        run_line(base, 8'd6, 4'd2, 0, 10, 0, 40);
        checks++;
        if (timed_out || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d expected 1", done_cnt);
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL busy_stream: first diff at %0d (got %0d pixels expected %0d)", d, obs_q.size(), exp_q.size());
        end
        d = addr_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL busy_addr: first diff at %0d (got %0d reads expected 6)", d, addr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_known_glyphs();
        test_random_stall();
        test_addr_wrap();
        test_reset_midline();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
